// File: rtl/itof_issue_queue.sv
// Integer-to-float issue queue: a small FIFO of signed 32-bit operands with tags.
// Each head entry is converted to IEEE-754 single precision on its way into a
// registered output slot.
module itof_issue_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]      r_mem_data [DEPTH];
  logic [TAG_W-1:0] r_mem_tag  [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;
  logic [31:0]      r_out_data;
  logic [TAG_W-1:0] r_out_tag;

  logic             w_in_ready;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_head;
  logic             w_sign;
  logic [31:0]      w_mag;
  logic [4:0]       w_lead;
  logic [31:0]      w_norm;
  logic [23:0]      w_mant_rnd;
  logic [7:0]       w_exp;
  logic [31:0]      w_fp;

  // Space is judged from the registered occupancy only, never from out_ready.
  assign w_in_ready = (r_count < CNT_W'(DEPTH));
  assign w_push     = in_valid && w_in_ready;
  assign w_pop      = (r_count != '0) && (!r_out_valid || out_ready);

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign count     = r_count;

  // Convert the FIFO head: normalise so the leading one sits at bit 31, then
  // round half away from zero using the first discarded bit.
  always_comb begin
    w_head     = r_mem_data[r_rptr];
    w_sign     = w_head[31];
    w_mag      = w_sign ? (~w_head + 32'd1) : w_head;
    w_lead     = '0;
    for (int i = 0; i < 32; i++) begin
      if (w_mag[i]) w_lead = 5'(i);
    end
    w_norm     = w_mag << (5'd31 - w_lead);
    w_mant_rnd = {1'b0, w_norm[30:8]} + 24'(w_norm[7]);
    w_exp      = 8'd127 + {3'b000, w_lead};
    if (w_mag == 32'd0) begin
      w_fp = 32'd0;
    end else if (w_mant_rnd[23]) begin
      w_fp = {w_sign, w_exp + 8'd1, 23'd0};
    end else begin
      w_fp = {w_sign, w_exp, w_mant_rnd[22:0]};
    end
  end

  // Storage array; contents are only ever read behind a valid count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= in_data;
      r_mem_tag[r_wptr]  <= in_tag;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // Output slot: load the converted head on pop, drop valid when drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_fp;
      r_out_tag   <= r_mem_tag[r_rptr];
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/itof_issue_queue.md
ITOF_ISSUE_QUEUE -- requirements
Module: itof_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of input FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TAG_W, default 6, meaning width of the destination-register tag carried with each operand.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers an integer operand.
REQ-006 SHALL have port in_ready  output  1  queue can accept an operand this cycle.
REQ-007 SHALL have port in_data  input  32  signed two's-complement integer.
REQ-008 SHALL have port in_tag  input  TAG_W  destination tag for in_data.
REQ-009 SHALL have port out_valid  output  1  out_data/out_tag hold a converted result.
REQ-010 SHALL have port out_ready  input  1  downstream (FP writeback) accepts the result.
REQ-011 SHALL have port out_data  output  32  IEEE-754 single-precision result.
REQ-012 SHALL have port out_tag  output  TAG_W  tag of the operand that produced out_data.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied FIFO entries (excludes output register).

Function
REQ-014 Input handshake: operand accepted on a rising edge where in_valid && in_ready; in_ready SHALL equal (count < DEPTH) and SHALL NOT depend combinationally on out_ready or in_valid.
REQ-015 Accepted operands SHALL be written at the write pointer; pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-016 No bypass: an operand accepted into an empty queue SHALL still be written to the FIFO first.
REQ-017 Output register SHALL load FIFO head (converted) on an edge where count>0 and (!out_valid || out_ready); the head is popped on that same edge.
REQ-018 Latency: operand accepted at edge N into empty queue with free output register SHALL appear with out_valid=1 after edge N+1; sustained throughput one result per cycle with out_ready=1.
REQ-019 Output stalling: while out_valid && !out_ready, out_data and out_tag SHALL hold stable and no pop SHALL occur.
REQ-020 out_valid SHALL clear on an edge where out_valid && out_ready and count==0.
REQ-021 count SHALL increment on push-only, decrement on pop-only, and stay unchanged on simultaneous push and pop (possible only when count<DEPTH).
REQ-022 Results SHALL leave in acceptance order, tag paired with its own data.
REQ-023 Conversion: sign = in_data[31]; magnitude = two's-complement absolute value; exponent = 127 + index of leading one of magnitude.
REQ-024 Mantissa SHALL be the 23 bits below the leading one (zero-filled if fewer exist); rounding adds 1 when the bit immediately below the mantissa LSB is 1 (round half away from zero on magnitude), other lower bits ignored.
REQ-025 If rounding carries out of all-ones mantissa, result SHALL be {sign, exponent+1, 23'b0}.
REQ-026 in_data==0 SHALL give out_data 0x00000000; in_data==0x80000000 SHALL give 0xCF000000.
REQ-027 Conversion logic SHALL be combinational between FIFO head and output register; no additional pipeline stage.

Reset
REQ-028 While rst=1 at an edge: write/read pointers 0, count 0, out_valid 0, out_data 0, out_tag 0; FIFO contents undefined and never observable.
REQ-029 rst SHALL override any concurrent push or pop; operands in flight are discarded, and in_ready SHALL be 1 on the cycle after rst deasserts.

Verification
REQ-030 in_data=1, tag=5, out_ready=1 into empty queue at edge N -> out_valid=1 after edge N+1, out_data=0x3F800000, out_tag=5.
REQ-031 in_data=0xFFFFFFFF (-1) -> 0xBF800000; in_data=0 -> 0x00000000; in_data=0x80000000 -> 0xCF000000.
REQ-032 in_data=0x01000001 -> 0x4B800001 (round up); in_data=0x01FFFFFF -> 0x4C000000 (mantissa overflow bumps exponent).
REQ-033 out_ready=0, push tags 1,2,3 back-to-back -> tag1 in output register, count=2, in_ready=0, 4th in_valid not accepted; raise out_ready -> tags 1,2,3 emerge on consecutive cycles, data unchanged while stalled.
REQ-034 Continuous in_valid/out_ready=1 for 10 operands -> one result per cycle, pointers wrap, order preserved, count never exceeds 1.
REQ-035 Assert rst with count=2 and out_valid=1 -> next cycle out_valid=0, count=0, in_ready=1, no stale result emitted afterwards.
